// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor front end.
// Holds the instruction field layout, opcode constants and the
// instruction-fetch state encoding used by instr_fetch.
package proc_pkg;

  // Memory word and IIIXXXYYY instruction field widths
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned RX_W    = 3;
  localparam int unsigned RY_W    = 3;

  // Opcodes (instruction bits [8:6])
  localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
  localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  // Issue counter saturation value
  localparam logic [WORD_W-1:0] ICOUNT_MAX = '1;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_IR   = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_WAIT_IMM  = 3'd4,
    S_ISSUE     = 3'd5,
    S_EXEC      = 3'd6,
    S_HALTED    = 3'd7
  } fetch_state_e;

  // Opcode field of a 9-bit instruction
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the instruction fetch sequencer.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   clr           : synchronous clear to 0 (wins over inc)
//   inc           : advance by one, wrapping at 2^ADDR_W
//   pc            : current counter value (registered)
module fetch_pc #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next count; natural ADDR_W-bit overflow gives the silent wrap
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer for the multicycle core.
// Reads instruction words from a one-cycle-latency memory, fetches the
// immediate word for mvi, hands ir/din to the core with a one-cycle run
// pulse and waits for done before the next fetch. Stops on the halt opcode.
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   start         : begin at address 0 (only from IDLE or HALTED)
//   mem_addr      : memory address (the pc register)
//   mem_rdata     : memory data, one cycle after mem_addr
//   ir, din       : instruction and immediate presented to the core
//   run           : one-cycle issue pulse
//   done          : core completion, looked at only while executing
//   pc            : current fetch address
//   busy, halted  : sequencer status
//   icount        : saturating count of issued instructions
module instr_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter logic [proc_pkg::OPC_W-1:0] OP_MVI  = proc_pkg::OP_MVI,
  parameter logic [proc_pkg::OPC_W-1:0] OP_HALT = proc_pkg::OP_HALT
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        start,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [proc_pkg::WORD_W-1:0] mem_rdata,
  output logic [proc_pkg::INSTR_W-1:0] ir,
  output logic [proc_pkg::WORD_W-1:0] din,
  output logic                        run,
  input  logic                        done,
  output logic [ADDR_W-1:0]           pc,
  output logic                        busy,
  output logic                        halted,
  output logic [proc_pkg::WORD_W-1:0] icount
);

  import proc_pkg::*;

  fetch_state_e         state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [WORD_W-1:0]    din_q, din_d;
  logic [WORD_W-1:0]    icount_q, icount_d;
  logic                 run_q, run_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 pc_clr;
  logic                 pc_inc;
  logic [ADDR_W-1:0]    pc_w;
  logic [OPC_W-1:0]     rd_opcode;

  // Opcode of the word currently returned by memory
  assign rd_opcode = opcode_of(mem_rdata[INSTR_W-1:0]);

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clock  (clock),
    .resetn (resetn),
    .clr    (pc_clr),
    .inc    (pc_inc),
    .pc     (pc_w)
  );

  // Next state, pc control and datapath register updates
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    din_d    = din_q;
    icount_d = icount_q;
    pc_clr   = 1'b0;
    pc_inc   = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_clr   = 1'b1;
          icount_d = '0;
          state_d  = S_FETCH;
        end
      end
      // Memory samples pc on the edge leaving this state
      S_FETCH: begin
        state_d = S_WAIT_IR;
      end
      // Halt words are latched into ir but never issued
      S_WAIT_IR: begin
        ir_d   = mem_rdata[INSTR_W-1:0];
        pc_inc = 1'b1;
        if (rd_opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (rd_opcode == OP_MVI) begin
          state_d = S_FETCH_IMM;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FETCH_IMM: begin
        state_d = S_WAIT_IMM;
      end
      S_WAIT_IMM: begin
        din_d   = mem_rdata;
        pc_inc  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (icount_q != ICOUNT_MAX) begin
          icount_d = icount_q + WORD_W'(1);
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (done) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs registered from the state being entered
  always_comb begin
    run_d    = (state_d == S_ISSUE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALTED);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      din_q    <= '0;
      icount_q <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      din_q    <= din_d;
      icount_q <= icount_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign mem_addr = pc_w;
  assign pc       = pc_w;
  assign ir       = ir_q;
  assign din      = din_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign icount   = icount_q;

endmodule
